ring_rr_arbiter: RTL and testbench
==================================

// Module: ring_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one downstream resource between N requesters.
//  - Priority is rotated by a one-hot ring token that marks the last grantee.
//  - The grant is held while the grantee keeps requesting.
//  - Sits in front of any shared counter or datapath stage that one client may own at a time.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  MAX_HOLD  8   max consecutive grant cycles per ownership (>=1); used only with RING_ARB_HOLD_LIMIT_EN
//  IDXW      $clog2(N)   width of gnt_idx (derived localparam)
// PORTS
//  clk        in   1     single clock; all state updates on posedge
//  rst        in   1     synchronous reset, active-high
//  req        in   N     per-requester request, level; sampled at posedge
//  gnt        out  N     one-hot grant, registered; all-zero when idle
//  gnt_valid  out  1     |gnt, registered
//  gnt_idx    out  IDXW  binary index of the granted requester; 0 when idle
//  token      out  N     one-hot ring pointer to the last grantee, registered
// BEHAVIOUR
//  - Reset (rst=1 at posedge): gnt=0, gnt_valid=0, gnt_idx=0, token=1<<(N-1), hold_cnt=0, state=IDLE.
//    - Requester 0 therefore has first priority.
//    - rst overrides every other event, including reset during an active grant.
//  - Pick: rotate-priority search from token index+1 upward, wrapping modulo N, ending at token index.
//    - The first set req bit wins.
//  - FSM states IDLE and OWN. There is no other state.
//  - IDLE:
//    - If |req, at the next posedge: gnt <= onehot(pick), token <= gnt, hold_cnt <= 0, state <= OWN.
//    - Latency from req asserted to gnt is 1 cycle.
//    - If req=0, the FSM stays in IDLE.
//  - OWN, with g = current grantee:
//    - Keep: req[g]=1 and no hold-limit event -> gnt unchanged, hold_cnt++.
//    - Release: req[g]=0 -> re-pick at the same posedge. If |req, hand over with zero bubble; otherwise go to IDLE.
//    - Hold limit (macro on): req[g]=1 and hold_cnt==MAX_HOLD-1 -> forced re-pick at that posedge.
//      - Because g has lowest rotated priority, another requester wins if present.
//      - If g is the only requester, g is re-granted, hold_cnt <= 0, and token stays at g.
//  - Invariants:
//    - gnt is one-hot or zero, never multi-hot.
//    - token is always one-hot.
//    - gnt_idx always encodes gnt.
//  - Fairness: with all N requesting continuously, grants cycle 0,1,..,N-1,0 and no requester waits more than N-1 ownerships.
//  - Requests from non-grantees arriving during OWN do not disturb the current grant.
//  - hold_cnt width is $clog2(MAX_HOLD+1). It saturates and never wraps.
// CONFIGURATION
//  RING_ARB_HOLD_LIMIT_EN
//  - Defined: hold-limit preemption is active as above, so an ownership lasts at most MAX_HOLD cycles.
//  - Undefined: no preemption. The grant is held until req[g] drops, hold_cnt logic is removed, and MAX_HOLD is ignored.
// STRUCTURE
//  - Package ring_arb_pkg:
//    - state enum {IDLE, OWN}
//    - function onehot2idx
//    - function rot_pick(req, token) returning one-hot
//  - Sub-module ring_arb_pick: combinational rotate-priority picker (req, token -> pick_oh, pick_any).
//  - Top-level ring_rr_arbiter holds the FSM, the registers and the hold counter.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, token=4'b1000. After rst drops, gnt=4'b0001 after 1 cycle and gnt_idx=0.
//  2. Rotation: req=4'b1111, each grantee drops its req for 1 cycle after owning -> grant order 0,1,2,3,0 with zero idle cycles between owners.
//  3. Single requester: only req[2]=1 from reset -> gnt=4'b0100 after 1 cycle. Drop req[2] -> gnt=0 and gnt_valid=0 next cycle.
//  4. Hold limit (macro on, MAX_HOLD=8):
//     - req[1] and req[3] held high -> gnt[1] for exactly 8 cycles, then gnt[3] for 8, then gnt[1] again.
//     - Macro off: gnt[1] is held indefinitely.
//  5. Reset mid-grant: gnt=4'b0100 with req=4'b0110, rst pulsed 1 cycle -> gnt=0 and token=4'b1000 next cycle, then gnt=4'b0010.
//  6. Wrap: token=4'b1000 with req=4'b1001 -> gnt=4'b0001 (index 0 wins), then after release gnt=4'b1000.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Supports up to MAXN requesters; the top rejects larger N at elaboration.
package ring_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int MAXN = 32;
    localparam int MAXW = 5;

    function automatic logic [31:0] onehot2idx(input logic [MAXN-1:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < MAXN; i++) begin
            if (oh[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

    // Search starts just after the token position and wraps, so the token holder is asked last.
    function automatic logic [MAXN-1:0] rot_pick(input logic [MAXN-1:0] req,
                                                 input logic [MAXN-1:0] token,
                                                 input int              n);
        logic [MAXN-1:0] res;
        logic            found;
        int              tidx;
        int              j;
        res   = '0;
        found = 1'b0;
        tidx  = 0;
        j     = 0;
        for (int i = 0; i < MAXN; i++) begin
            if (token[i]) tidx = i;
        end
        for (int k = 1; k <= MAXN; k++) begin
            if (k <= n) begin
                j = (tidx + k) % n;
                if (!found && req[j[MAXW-1:0]]) begin
                    res[j[MAXW-1:0]] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ring_arb_pick.sv
// Combinational rotate-priority picker: lowest priority goes to the token holder.
module ring_arb_pick
    import ring_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] token,
    output logic [N-1:0] pick_oh,
    output logic         pick_any
);

    assign pick_oh  = N'(rot_pick(MAXN'(req), MAXN'(token), N));
    assign pick_any = |pick_oh;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring token marking the last grantee.
// Define RING_ARB_HOLD_LIMIT_EN to cap each ownership at MAX_HOLD cycles.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    token
);

    if (N < 2 || N > MAXN || MAX_HOLD < 1) begin : g_bad_params
        $error("ring_rr_arbiter: N must be 2..%0d and MAX_HOLD >= 1", MAXN);
    end

    state_t       state_q, state_d;
    logic [N-1:0] gnt_d, token_d, pick_oh;
    logic         pick_any, repick, own_req, hold_hit;

    ring_arb_pick #(.N(N)) u_pick (
        .req      (req),
        .token    (token),
        .pick_oh  (pick_oh),
        .pick_any (pick_any)
    );

    // A requester owns the resource for as long as it keeps req high after
    // seeing its gnt bit; dropping req releases it at the next edge.
    assign own_req = |(req & gnt);

`ifdef RING_ARB_HOLD_LIMIT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hold_cnt;

    assign hold_hit = (hold_cnt == HCW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (repick) begin
            hold_cnt <= '0;
        end else if (state_q == OWN && hold_cnt != HCW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        token_d = token;
        repick  = 1'b0;
        case (state_q)
            IDLE:    repick = pick_any;
            OWN:     repick = !own_req || hold_hit;
            default: repick = 1'b0;
        endcase
        // Token stays put on the way to IDLE so the next pick still rotates past the last owner.
        if (repick) begin
            if (pick_any) begin
                gnt_d   = pick_oh;
                token_d = pick_oh;
                state_d = OWN;
            end else begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            token     <= {1'b1, {(N-1){1'b0}}};
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            gnt_valid <= |gnt_d;
            gnt_idx   <= IDXW'(onehot2idx(MAXN'(gnt_d)));
            token     <= token_d;
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: vector table, hold-limit sequences
// and a randomized run against a small behavioural model.
module tb_ring_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDXW     = 2;
    localparam int W        = 2 * N;
`ifdef RING_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [N-1:0] tok;
        string        name;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    token;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int m_own, m_tok, m_hc;

    vec_t vecs[22];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .token     (token)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int idx_of(input logic [N-1:0] g);
        int r = 0;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_out(input string name);
        logic [W-1:0] e;
        logic [N-1:0] eg, et;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: output seen with no expected entry queued", name);
            return;
        end
        e  = exp_q.pop_front();
        eg = e[W-1:N];
        et = e[N-1:0];
        total++;
        if (gnt !== eg) begin
            bad++; $display("FAIL %s gnt: got %b want %b", name, gnt, eg);
        end
        total++;
        if (token !== et) begin
            bad++; $display("FAIL %s token: got %b want %b", name, token, et);
        end
        total++;
        if (gnt_valid !== (|eg)) begin
            bad++; $display("FAIL %s gnt_valid: got %b want %b", name, gnt_valid, |eg);
        end
        total++;
        if (gnt_idx !== IDXW'(idx_of(eg))) begin
            bad++; $display("FAIL %s gnt_idx: got %0d want %0d", name, gnt_idx, idx_of(eg));
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [N-1:0] q,
                         input logic [N-1:0] eg, input logic [N-1:0] et,
                         input string name);
        @(negedge clk);
        rst = r;
        req = q;
        exp_q.push_back({eg, et});
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    // Behavioural reference: integer owner/token indices.
    task automatic model_step(input logic r, input logic [N-1:0] q,
                              output logic [N-1:0] eg, output logic [N-1:0] et);
        bit rp;
        int nxt;
        int i;
        if (r) begin
            m_own = -1; m_tok = N - 1; m_hc = 0;
        end else begin
            if (m_own < 0) rp = (q != '0);
            else rp = (((q >> m_own) & N'(1)) == '0) || (HOLD_EN && m_hc == MAX_HOLD - 1);
            if (rp) begin
                nxt = -1;
                for (int k = 1; k <= N; k++) begin
                    i = (m_tok + k) % N;
                    if (nxt < 0 && ((q >> i) & N'(1)) != '0) nxt = i;
                end
                if (nxt >= 0) begin
                    m_own = nxt; m_tok = nxt;
                end else begin
                    m_own = -1;
                end
                m_hc = 0;
            end else if (m_own >= 0 && m_hc < MAX_HOLD) begin
                m_hc++;
            end
        end
        eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
        et = N'(1) << m_tok;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] eg, et, q;
        logic         r;

        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, "reset_a"};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, "reset_b"};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, "first_grant"};
        vecs[3]  = '{1'b0, 4'b1110, 4'b0010, 4'b0010, "rot_1"};
        vecs[4]  = '{1'b0, 4'b1101, 4'b0100, 4'b0100, "rot_2"};
        vecs[5]  = '{1'b0, 4'b1011, 4'b1000, 4'b1000, "rot_3"};
        vecs[6]  = '{1'b0, 4'b0111, 4'b0001, 4'b0001, "rot_wrap_0"};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b1000, "reset_c"};
        vecs[8]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, "single_grant"};
        vecs[9]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, "single_keep"};
        vecs[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0100, "single_release"};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0100, "idle_stay"};
        vecs[12] = '{1'b1, 4'b0000, 4'b0000, 4'b1000, "reset_d"};
        vecs[13] = '{1'b0, 4'b0100, 4'b0100, 4'b0100, "mid_grant"};
        vecs[14] = '{1'b0, 4'b0110, 4'b0100, 4'b0100, "no_disturb"};
        vecs[15] = '{1'b1, 4'b0110, 4'b0000, 4'b1000, "reset_mid_grant"};
        vecs[16] = '{1'b0, 4'b0110, 4'b0010, 4'b0010, "after_reset"};
        vecs[17] = '{1'b1, 4'b0000, 4'b0000, 4'b1000, "reset_e"};
        vecs[18] = '{1'b0, 4'b1001, 4'b0001, 4'b0001, "wrap_idx0"};
        vecs[19] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, "wrap_handover"};
        vecs[20] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, "wrap_keep"};
        vecs[21] = '{1'b0, 4'b0000, 4'b0000, 4'b1000, "wrap_idle"};

        for (int v = 0; v < 22; v++) begin
            drive(vecs[v].rst, vecs[v].req, vecs[v].gnt, vecs[v].tok, vecs[v].name);
        end

        // Two continuous requesters: hold limit alternates them, otherwise 1 keeps the grant.
        drive(1'b1, 4'b0000, 4'b0000, 4'b1000, "hold_reset");
        for (int c = 0; c < 3 * MAX_HOLD; c++) begin
            if (HOLD_EN && ((c / MAX_HOLD) % 2) == 1) eg = 4'b1000;
            else eg = 4'b0010;
            drive(1'b0, 4'b1010, eg, eg, "hold_pair");
        end

        // Lone requester is re-granted without a gap even when the limit fires.
        drive(1'b1, 4'b0000, 4'b0000, 4'b1000, "lone_reset");
        for (int c = 0; c < MAX_HOLD + 4; c++) begin
            drive(1'b0, 4'b0100, 4'b0100, 4'b0100, "lone_hold");
        end

        // Randomized traffic against the reference model.
        q = '0;
        for (int c = 0; c < 250; c++) begin
            r = (c == 0) || ($urandom_range(0, 59) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) q[b] = ~q[b];
            end
            model_step(r, q, eg, et);
            drive(r, q, eg, et, "random");
        end

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
